fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer for the 8-bit CPU. Drives the program counter's
//   loadPC/incPC controls and reads 1-3 instruction bytes from memory through a
//   req/ack handshake, using the PC output as the fetch address.
//   Presents the assembled instruction to the execute stage with a valid/ready
//   handshake. Accepts branch redirects from execute and a halt request.
// PARAMETERS
//   ADDR_W     16       address / PC width
//   RESET_VEC  16'h0000 PC value loaded after reset release
// PORTS
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       asynchronous active-low reset
//   pc_addr       in   ADDR_W  current PC value (PC execadd output)
//   loadPC        out  1       PC load strobe
//   incPC         out  1       PC increment strobe
//   pc_load_addr  out  ADDR_W  PC load value, meaningful while loadPC=1
//   mem_req       out  1       memory read request
//   mem_addr      out  ADDR_W  read address; combinational copy of pc_addr
//   mem_rdata     in   8       read data, valid with mem_ack
//   mem_ack       in   1       one-cycle read completion
//   ir_opcode     out  8       fetched opcode
//   ir_operand    out  16      operand {B2,B1}; B1 = low byte
//   ir_valid      out  1       instruction available
//   ir_ready      in   1       execute accepts instruction
//   branch_req    in   1       redirect request, one-cycle pulse
//   branch_target in   ADDR_W  redirect address
//   halt          in   1       level halt request
//   halted        out  1       sequencer idle in HALTED
// BEHAVIOUR
//   Reset (rst_n=0, immediate): state=RESET_LD; loadPC, incPC, mem_req,
//     ir_valid, halted=0; ir_opcode, ir_operand=0; pc_load_addr=RESET_VEC.
//     An outstanding memory read is abandoned, and mem_ack is ignored until FETCH_OP.
//   States: RESET_LD, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE, HALTED.
//   RESET_LD: loadPC=1 for exactly 1 cycle with RESET_VEC -> FETCH_OP.
//   Instruction length from the captured opcode[7:6]: 00=1 byte, 01=2 bytes, 1x=3 bytes.
//   FETCH_*: mem_req=1 until mem_ack. On the ack cycle: capture mem_rdata into
//     opcode/B1/B2, incPC=1 for that cycle only, advance. The PC updates at the
//     same edge, so the next byte reads the incremented address.
//     Last byte -> ISSUE. Unused operand bytes are 0 (2-byte: operand={8'h00,B1}).
//   ISSUE: ir_valid=1. mem_req=0, and opcode/operand are held stable until ir_valid&ir_ready.
//     On the handshake: ir_valid=0 next cycle. Next state is HALTED if halt=1,
//     else FETCH_OP.
//   HALTED: halted=1, no mem_req, no incPC. halt=0 -> FETCH_OP.
//   branch_req (any state except RESET_LD) has priority over everything else:
//     - loadPC=1 with pc_load_addr=branch_target in the same cycle.
//     - Partial bytes are discarded.
//     - A mem_ack in that cycle is dropped: no capture, no incPC.
//     - ir_valid=0 next cycle. If the ISSUE handshake coincides, that instruction
//       counts as consumed.
//     - Next state is FETCH_OP, or HALTED if in HALTED with halt=1.
//   loadPC and incPC are never asserted in the same cycle. incPC fires once per accepted mem_ack.
//   PC wrap (0xFFFF -> 0x0000) is handled by the PC; no special action here.
//   mem_ack outside FETCH_* is ignored.
// TESTING
//   1. Release rst_n; mem[0]=0x05 with immediate ack -> loadPC pulse with 0x0000;
//      mem_addr=0x0000; one incPC; ir_valid with opcode 0x05, operand 0x0000.
//   2. Branch to 0x1234; bytes 80,78,56, each with 2 wait cycles -> three incPC
//      pulses, one per ack; ir_operand=0x5678; PC=0x1237 at ISSUE.
//   3. ir_ready low 5 cycles in ISSUE -> ir_opcode/ir_operand stable; no mem_req,
//      incPC or loadPC; fetch resumes the cycle after the handshake.
//   4. branch_req (target 0x5678) on the same cycle as the B1 ack of a 3-byte op ->
//      loadPC with 0x5678; no incPC; no ir_valid for the partial op; next mem_addr=0x5678.
//   5. halt=1 at the ISSUE handshake -> halted=1, mem_req=0 for 10 cycles; halt=0 ->
//      FETCH_OP at the unchanged PC.
//   6. rst_n low mid-FETCH_B1 with mem_ack arriving -> all outputs reset immediately
//      with no capture; on release, RESET_LD reloads RESET_VEC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives PC load/increment, reads 1-3 bytes per instruction
// through a req/ack port and hands the assembled instruction to execute via valid/ready.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              loadPC,
  output logic              incPC,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        ir_opcode,
  output logic [15:0]       ir_operand,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic [2:0] {
    StResetLd, StFetchOp, StFetchB1, StFetchB2, StIssue, StHalted
  } state_e;

  state_e      state_q, state_d;
  logic        rst_load_q, rst_load_d;
  logic        ir_valid_q, ir_valid_d;
  logic        halted_q, halted_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] operand_q, operand_d;

  logic in_fetch, branch_take, ack_take;

  always_comb begin
    in_fetch    = (state_q == StFetchOp) || (state_q == StFetchB1) || (state_q == StFetchB2);
    branch_take = branch_req && (state_q != StResetLd);
    // A redirect wins over a completing read: the byte is dropped and the PC not bumped.
    ack_take    = in_fetch && mem_ack && !branch_take;

    loadPC       = rst_load_q || branch_take;
    pc_load_addr = branch_take ? branch_target : RESET_VEC;
    incPC        = ack_take;
    mem_req      = in_fetch && !branch_take;
    mem_addr     = pc_addr;
  end

  always_comb begin
    state_d    = state_q;
    rst_load_d = 1'b0;
    opcode_d   = opcode_q;
    operand_d  = operand_q;

    if (branch_take) begin
      state_d = (state_q == StHalted && halt) ? StHalted : StFetchOp;
    end else begin
      unique case (state_q)
        StResetLd: begin
          // First cycle after release arms the load strobe; second cycle performs it.
          rst_load_d = !rst_load_q;
          if (rst_load_q) state_d = StFetchOp;
        end
        StFetchOp: begin
          if (ack_take) begin
            opcode_d  = mem_rdata;
            operand_d = 16'h0000;
            state_d   = (mem_rdata[7:6] == 2'b00) ? StIssue : StFetchB1;
          end
        end
        StFetchB1: begin
          if (ack_take) begin
            operand_d[7:0] = mem_rdata;
            state_d        = (opcode_q[7:6] == 2'b01) ? StIssue : StFetchB2;
          end
        end
        StFetchB2: begin
          if (ack_take) begin
            operand_d[15:8] = mem_rdata;
            state_d         = StIssue;
          end
        end
        StIssue: begin
          if (ir_ready) state_d = halt ? StHalted : StFetchOp;
        end
        StHalted: begin
          if (!halt) state_d = StFetchOp;
        end
        default: state_d = StResetLd;
      endcase
    end

    ir_valid_d = (state_d == StIssue);
    halted_d   = (state_d == StHalted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StResetLd;
      rst_load_q <= 1'b0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      opcode_q   <= 8'h00;
      operand_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      rst_load_q <= rst_load_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
    end
  end

  assign ir_valid   = ir_valid_q;
  assign halted     = halted_q;
  assign ir_opcode  = opcode_q;
  assign ir_operand = operand_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models the external PC, serves bytes by hand and scoreboards
// issued instructions against expectations queued by the stimulus.
module tb_fetch_ctrl;

  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] pc_addr;
  logic              loadPC, incPC, mem_req, ir_valid, halted;
  logic [ADDR_W-1:0] pc_load_addr, mem_addr;
  logic [7:0]        mem_rdata, ir_opcode;
  logic              mem_ack, ir_ready, branch_req, halt;
  logic [15:0]       ir_operand;
  logic [ADDR_W-1:0] branch_target;

  int n_checks = 0;
  int n_fail   = 0;
  int inc_cnt  = 0;
  logic [23:0] exp_q[$];

  fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .loadPC(loadPC), .incPC(incPC),
    .pc_load_addr(pc_load_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir_opcode(ir_opcode),
    .ir_operand(ir_operand), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .branch_req(branch_req), .branch_target(branch_target), .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  // External program counter, not reset: only loadPC/incPC move it.
  always @(posedge clk) begin
    if (loadPC) pc_addr <= pc_load_addr;
    else if (incPC) pc_addr <= pc_addr + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && incPC) inc_cnt++;
    if (rst_n) check("no_load_and_inc", {31'd0, loadPC && incPC}, 32'd0);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h, expected no instruction", {ir_opcode, ir_operand});
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("sb_instr", {8'd0, ir_opcode, ir_operand}, {8'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a fetch request, holds it `waits` cycles, then acks with `data`.
  task automatic serve(input logic [7:0] data, input int waits);
    int t = 0;
    while (!mem_req && t < 50) begin tick(); t++; end
    check("serve_req_seen", {31'd0, mem_req}, 32'd1);
    repeat (waits) tick();
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    check("serve_incpc", {30'd0, incPC, loadPC}, 32'd2);
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    check("sb_drained", exp_q.size(), 32'd0);
    tick();
  endtask

  task automatic expect_reset_load();
    int t = 0;
    @(negedge clk);
    while (!loadPC && t < 10) begin @(negedge clk); t++; end
    check("rst_loadpc_seen", {31'd0, loadPC}, 32'd1);
    check("rst_load_addr", pc_load_addr, 32'h0000);
    @(negedge clk);
    check("rst_load_once", {31'd0, loadPC}, 32'd0);
    check("rst_fetch_addr", {31'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});
    tick();
  endtask

  initial begin
    logic [15:0] saved_pc;
    int          inc0;
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; ir_ready = 1'b1;
    branch_req = 1'b0; branch_target = '0; halt = 1'b0;
    #2;
    check("reset_ctrl", {27'd0, loadPC, incPC, mem_req, ir_valid, halted}, 32'd0);
    check("reset_ir", {8'd0, ir_opcode, ir_operand}, 32'd0);
    check("reset_load_addr", pc_load_addr, 32'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset vector load, single-byte op
    expect_reset_load();
    exp_q.push_back({8'h05, 16'h0000});
    serve(8'h05, 0);
    drain();

    // 2: branch to 0x1234, three-byte op with wait states
    ir_ready = 1'b0;
    branch_req = 1'b1; branch_target = 16'h1234;
    @(negedge clk);
    check("br_load", {15'd0, loadPC, incPC, pc_load_addr}, {15'd0, 2'b10, 16'h1234});
    tick();
    branch_req = 1'b0;
    inc0 = inc_cnt;
    serve(8'h80, 2);
    serve(8'h78, 2);
    serve(8'h56, 2);
    check("t2_inc_count", inc_cnt - inc0, 32'd3);
    check("t2_pc_at_issue", pc_addr, 32'h1237);
    check("t2_issue", {7'd0, ir_valid, ir_opcode, ir_operand}, {7'd0, 1'b1, 8'h80, 16'h5678});

    // 3: stall in ISSUE
    repeat (5) begin
      @(negedge clk);
      check("t3_stable", {8'd0, ir_opcode, ir_operand}, {8'd0, 8'h80, 16'h5678});
      check("t3_quiet", {29'd0, mem_req, incPC, loadPC}, 32'd0);
      tick();
    end
    exp_q.push_back({8'h80, 16'h5678});
    ir_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t3_resume", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h1237});
    tick();

    // 4: branch coincident with B1 ack of a three-byte op
    serve(8'hC0, 0);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    branch_req = 1'b1; branch_target = 16'h5678;
    @(negedge clk);
    check("t4_load", {15'd0, loadPC, incPC, pc_load_addr}, {15'd0, 2'b10, 16'h5678});
    tick();
    mem_ack = 1'b0; branch_req = 1'b0;
    @(negedge clk);
    check("t4_redirect", {14'd0, ir_valid, mem_req, mem_addr}, {14'd0, 2'b01, 16'h5678});
    tick();
    exp_q.push_back({8'h01, 16'h0000});
    serve(8'h01, 0);
    drain();
    check("t4_pc_after", pc_addr, 32'h5679);
    exp_q.push_back({8'h4A, 16'h009C});
    serve(8'h4A, 1);
    serve(8'h9C, 0);
    drain();

    // 5: halt at the ISSUE handshake
    halt = 1'b1;
    exp_q.push_back({8'h02, 16'h0000});
    serve(8'h02, 0);
    tick();
    saved_pc = pc_addr;
    check("t5_saved_pc", saved_pc, 32'h567C);
    repeat (10) begin
      @(negedge clk);
      check("t5_halted", {30'd0, halted, mem_req}, 32'd2);
      tick();
    end
    halt = 1'b0;
    tick();
    @(negedge clk);
    check("t5_resume", {14'd0, halted, mem_req, mem_addr}, {14'd0, 2'b01, saved_pc});
    tick();

    // 5b: branch while halted keeps HALTED
    halt = 1'b1;
    exp_q.push_back({8'h03, 16'h0000});
    serve(8'h03, 0);
    tick();
    branch_req = 1'b1; branch_target = 16'h2000;
    @(negedge clk);
    check("t5b_load", {15'd0, loadPC, halted, pc_load_addr}, {15'd0, 2'b11, 16'h2000});
    tick();
    branch_req = 1'b0;
    @(negedge clk);
    check("t5b_stay", {30'd0, halted, mem_req}, 32'd2);
    halt = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("t5b_resume", {14'd0, halted, mem_req, mem_addr}, {14'd0, 2'b01, 16'h2000});
    tick();

    // 6: reset mid-B1 while an ack arrives
    serve(8'hC5, 0);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_reset_ctrl", {27'd0, loadPC, incPC, mem_req, ir_valid, halted}, 32'd0);
    check("t6_reset_ir", {8'd0, ir_opcode, ir_operand}, 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_reset_load();
    exp_q.push_back({8'h00, 16'h0000});
    serve(8'h00, 0);
    drain();
    check("t6_pc_after", pc_addr, 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
